// File: rtl/fetch_arbiter_pkg.sv
// Shared types and helpers for the program-memory fetch arbiter.
// Optional broadcast serving is selected by FETCH_ARBITER_BCAST_EN in fetch_arbiter.sv.
package fetch_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        RELAY    = 2'd2
    } arb_state_t;

    // A single requester still needs a one-bit pointer.
    function automatic int ptr_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fetch_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
module rr_picker
    import fetch_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_bits(N)
) (
    input  logic [N-1:0]     request,
    input  logic [PTR_W-1:0] last_grant,
    output logic             found,
    output logic [PTR_W-1:0] winner
);

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = N; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % N;
            if (request[idx]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among instruction fetchers.
// Define FETCH_ARBITER_BCAST_EN to serve every same-address requester from one memory read.
//
// state    | meaning
// IDLE     | arbitrate among pending fetchers, launch memory read for the winner
// WAIT_MEM | memory request held stable until mem_read_ready
// RELAY    | data presented to served fetchers until each drops its valid
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data
);

    localparam int PTR_W = ptr_bits(NUM_CONSUMERS);
    localparam logic [PTR_W-1:0] LAST_RESET = PTR_W'(NUM_CONSUMERS - 1);

    arb_state_t               state, state_n;
    logic [PTR_W-1:0]         last_grant, last_grant_n;
    logic [NUM_CONSUMERS-1:0] serve_mask, serve_mask_n;
    logic                     mem_valid_n;
    logic [ADDR_BITS-1:0]     mem_addr_n;
    logic [NUM_CONSUMERS-1:0] ready_n;
    logic [DATA_BITS-1:0]     data_n [NUM_CONSUMERS];

    logic                     found;
    logic [PTR_W-1:0]         winner;
    logic [ADDR_BITS-1:0]     win_addr;
    logic [NUM_CONSUMERS-1:0] grant_mask;

    rr_picker #(
        .N     (NUM_CONSUMERS),
        .PTR_W (PTR_W)
    ) u_picker (
        .request    (consumer_read_valid),
        .last_grant (last_grant),
        .found      (found),
        .winner     (winner)
    );

    assign win_addr = consumer_read_address[winner];

`ifdef FETCH_ARBITER_BCAST_EN
    always_comb begin
        grant_mask = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            grant_mask[i] = consumer_read_valid[i] && (consumer_read_address[i] == win_addr);
        end
        grant_mask[winner] = 1'b1;
    end
`else
    always_comb begin
        grant_mask         = '0;
        grant_mask[winner] = 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= IDLE;
            last_grant          <= LAST_RESET;
            serve_mask          <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_read_data[i] <= '0;
            end
        end else begin
            state               <= state_n;
            last_grant          <= last_grant_n;
            serve_mask          <= serve_mask_n;
            mem_read_valid      <= mem_valid_n;
            mem_read_address    <= mem_addr_n;
            consumer_read_ready <= ready_n;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_read_data[i] <= data_n[i];
            end
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        serve_mask_n = serve_mask;
        mem_valid_n  = mem_read_valid;
        mem_addr_n   = mem_read_address;
        ready_n      = consumer_read_ready;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            data_n[i] = consumer_read_data[i];
        end

        case (state)
            IDLE: begin
                if (found) begin
                    last_grant_n = winner;
                    mem_valid_n  = 1'b1;
                    mem_addr_n   = win_addr;
                    serve_mask_n = grant_mask;
                    state_n      = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                // Requesters withdrawing here still get served; the access is never aborted.
                if (mem_read_ready) begin
                    mem_valid_n = 1'b0;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (serve_mask[i]) begin
                            ready_n[i] = 1'b1;
                            data_n[i]  = mem_read_data;
                        end
                    end
                    state_n = RELAY;
                end
            end
            RELAY: begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    if (serve_mask[i] && !consumer_read_valid[i]) begin
                        ready_n[i]      = 1'b0;
                        serve_mask_n[i] = 1'b0;
                    end
                end
                if (serve_mask_n == '0) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n      = IDLE;
                serve_mask_n = '0;
                mem_valid_n  = 1'b0;
                ready_n      = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed self-checking bench for fetch_arbiter with a behavioural program memory.
module tb_fetch_arbiter;

    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 16;

    logic          clk;
    logic          reset;
    logic [NC-1:0] consumer_read_valid;
    logic [AB-1:0] consumer_read_address [NC];
    logic [NC-1:0] consumer_read_ready;
    logic [DB-1:0] consumer_read_data [NC];
    logic          mem_read_valid;
    logic [AB-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DB-1:0] mem_read_data;

    int checks = 0;
    int errors = 0;
    int mem_delay = 0;
    int mem_accesses = 0;
    logic [AB-1:0] grant_log [$];

    fetch_arbiter #(
        .NUM_CONSUMERS (NC),
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (consumer_read_valid),
        .consumer_read_address (consumer_read_address),
        .consumer_read_ready   (consumer_read_ready),
        .consumer_read_data    (consumer_read_data),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DB-1:0] mem_fn(input logic [AB-1:0] a);
        return (a == 8'h12) ? 16'hABCD : {a ^ 8'h5A, a};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Program memory: answers mem_delay cycles after seeing the request, one-cycle ready pulse.
    initial begin
        int wait_cnt;
        wait_cnt       = 0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clk);
            if (mem_read_valid && !mem_read_ready) begin
                if (wait_cnt >= mem_delay) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem_fn(mem_read_address);
                    mem_accesses++;
                    grant_log.push_back(mem_read_address);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                mem_read_ready = 1'b0;
                wait_cnt       = 0;
            end
        end
    end

    // Fetcher: request, wait for ready, drop valid, re-request two cycles later.
    task automatic fetcher(input int id, input int count);
        int served;
        bit seen;
        served = 0;
        for (int n = 0; n < count; n++) begin
            consumer_read_address[id] = 8'h10 + 8'(id);
            consumer_read_valid[id]   = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                if (consumer_read_ready[id]) seen = 1'b1;
            end
            check_val($sformatf("fair_seen%0d", id), 32'(seen), 32'd1);
            if (!seen) break;
            check_val($sformatf("fair_data%0d", id), 32'(consumer_read_data[id]),
                      32'(mem_fn(8'h10 + 8'(id))));
            served++;
            consumer_read_valid[id] = 1'b0;
            step(2);
        end
        check_val($sformatf("fair_count%0d", id), 32'(served), 32'(count));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int base;
        reset = 1'b0;
        consumer_read_valid = '0;
        for (int i = 0; i < NC; i++) consumer_read_address[i] = '0;
        step(3);
        check_val("rst_mem_valid", 32'(mem_read_valid), 32'd0);
        check_val("rst_mem_addr", 32'(mem_read_address), 32'd0);
        check_val("rst_ready", 32'(consumer_read_ready), 32'd0);
        for (int i = 0; i < NC; i++) check_val("rst_data", 32'(consumer_read_data[i]), 32'd0);
        reset = 1'b1;
        step(1);

        // Reset during WAIT_MEM abandons the access
        mem_delay = 20;
        consumer_read_address[0] = 8'h30;
        consumer_read_valid[0]   = 1'b1;
        step(1);
        check_val("mr_mem_valid", 32'(mem_read_valid), 32'd1);
        step(2);
        reset = 1'b0;
        step(1);
        check_val("mr_mem_valid_clr", 32'(mem_read_valid), 32'd0);
        check_val("mr_ready_clr", 32'(consumer_read_ready), 32'd0);
        reset = 1'b1;
        consumer_read_valid = '0;
        step(1);
        mem_delay = 0;
        consumer_read_address[0] = 8'h20;
        consumer_read_address[2] = 8'h22;
        consumer_read_valid = 4'b0101;
        step(1);
        check_val("mr_first_addr", 32'(mem_read_address), 32'h20);
        check_val("mr_first_valid", 32'(mem_read_valid), 32'd1);
        step(1);
        check_val("mr_first_ready", 32'(consumer_read_ready), 32'b0001);
        check_val("mr_first_data", 32'(consumer_read_data[0]), 32'(mem_fn(8'h20)));
        consumer_read_valid[0] = 1'b0;
        step(1);
        check_val("mr_release", 32'(consumer_read_ready), 32'd0);
        check_val("mr_idle_novalid", 32'(mem_read_valid), 32'd0);
        step(1);
        check_val("mr_second_addr", 32'(mem_read_address), 32'h22);
        step(1);
        check_val("mr_second_ready", 32'(consumer_read_ready), 32'b0100);
        consumer_read_valid[2] = 1'b0;
        step(2);

        // Single requester latency, memory answers immediately
        consumer_read_address[1] = 8'h12;
        consumer_read_valid[1]   = 1'b1;
        step(1);
        check_val("lat_mem_valid", 32'(mem_read_valid), 32'd1);
        check_val("lat_mem_addr", 32'(mem_read_address), 32'h12);
        check_val("lat_no_early", 32'(consumer_read_ready), 32'd0);
        step(1);
        check_val("lat_ready", 32'(consumer_read_ready), 32'b0010);
        check_val("lat_data", 32'(consumer_read_data[1]), 32'hABCD);
        check_val("lat_mem_drop", 32'(mem_read_valid), 32'd0);
        consumer_read_valid[1] = 1'b0;
        step(1);
        check_val("lat_ready_drop", 32'(consumer_read_ready), 32'd0);
        check_val("lat_data_keep", 32'(consumer_read_data[1]), 32'hABCD);
        step(1);

        // Memory stalls five cycles
        mem_delay = 5;
        consumer_read_address[3] = 8'h55;
        consumer_read_valid[3]   = 1'b1;
        step(1);
        for (int k = 0; k < 5; k++) begin
            check_val("stall_valid", 32'(mem_read_valid), 32'd1);
            check_val("stall_addr", 32'(mem_read_address), 32'h55);
            check_val("stall_ready", 32'(consumer_read_ready), 32'd0);
            step(1);
        end
        check_val("stall_valid_end", 32'(mem_read_valid), 32'd1);
        check_val("stall_ready_end", 32'(consumer_read_ready), 32'd0);
        step(1);
        check_val("stall_done", 32'(consumer_read_ready), 32'b1000);
        check_val("stall_data", 32'(consumer_read_data[3]), 32'(mem_fn(8'h55)));
        consumer_read_valid[3] = 1'b0;
        step(2);
        mem_delay = 0;

        // Two fetchers on the same address
        acc0 = mem_accesses;
        consumer_read_address[0] = 8'h40;
        consumer_read_address[3] = 8'h40;
        consumer_read_valid = 4'b1001;
        step(1);
        check_val("same_addr", 32'(mem_read_address), 32'h40);
        step(1);
`ifdef FETCH_ARBITER_BCAST_EN
        check_val("bcast_ready", 32'(consumer_read_ready), 32'b1001);
        check_val("bcast_data0", 32'(consumer_read_data[0]), 32'(mem_fn(8'h40)));
        check_val("bcast_data3", 32'(consumer_read_data[3]), 32'(mem_fn(8'h40)));
        consumer_read_valid[0] = 1'b0;
        step(1);
        check_val("bcast_rel0", 32'(consumer_read_ready), 32'b1000);
        consumer_read_valid[3] = 1'b0;
        step(1);
        check_val("bcast_rel3", 32'(consumer_read_ready), 32'd0);
        step(2);
        check_val("bcast_accesses", 32'(mem_accesses - acc0), 32'd1);
`else
        check_val("same_first", 32'(consumer_read_ready), 32'b0001);
        consumer_read_valid[0] = 1'b0;
        step(1);
        check_val("same_rel0", 32'(consumer_read_ready), 32'd0);
        step(1);
        check_val("same_second_valid", 32'(mem_read_valid), 32'd1);
        step(1);
        check_val("same_second", 32'(consumer_read_ready), 32'b1000);
        consumer_read_valid[3] = 1'b0;
        step(2);
        check_val("same_accesses", 32'(mem_accesses - acc0), 32'd2);
`endif

        // Fetcher 2 lingers on valid while fetcher 0 waits
        consumer_read_address[2] = 8'h33;
        consumer_read_valid[2]   = 1'b1;
        step(2);
        consumer_read_address[0] = 8'h01;
        consumer_read_valid[0]   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_val("hold_ready", 32'(consumer_read_ready), 32'b0100);
            check_val("hold_data", 32'(consumer_read_data[2]), 32'(mem_fn(8'h33)));
            check_val("hold_no_grant", 32'(mem_read_valid), 32'd0);
            step(1);
        end
        consumer_read_valid[2] = 1'b0;
        step(1);
        check_val("hold_release", 32'(consumer_read_ready), 32'd0);
        check_val("hold_idle", 32'(mem_read_valid), 32'd0);
        step(1);
        check_val("hold_next_valid", 32'(mem_read_valid), 32'd1);
        check_val("hold_next_addr", 32'(mem_read_address), 32'h01);
        step(1);
        check_val("hold_next_ready", 32'(consumer_read_ready), 32'b0001);
        consumer_read_valid[0] = 1'b0;
        step(2);

        // Fairness from reset with all fetchers busy
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        base = grant_log.size();
        fork
            fetcher(0, 10);
            fetcher(1, 10);
            fetcher(2, 10);
            fetcher(3, 10);
        join
        check_val("fair_total", 32'(grant_log.size() - base), 32'd40);
        for (int k = 0; k < 40 && (base + k) < grant_log.size(); k++) begin
            check_val($sformatf("fair_order%0d", k), 32'(grant_log[base + k]),
                      32'(8'h10 + 8'(k % 4)));
        end

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
